// File: rtl/rpc_init_pkg.sv
// Shared types for the RPC DRAM register init sequencer: table entries,
// register-bus structs, FSM state encoding and the default boot table.
package rpc_init_pkg;

    localparam int unsigned AddrWidth    = 48;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned StrbWidth    = 4;
    localparam int unsigned MaxWaitWidth = 16;

    typedef struct packed {
        logic [AddrWidth-1:0]    offset;
        logic [DataWidth-1:0]    data;
        logic [MaxWaitWidth-1:0] wait_cycles;
    } init_entry_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

    typedef logic [1:0] state_e;
    localparam state_e StIdle  = 2'd0;
    localparam state_e StWrite = 2'd1;
    localparam state_e StWait  = 2'd2;
    localparam state_e StDone  = 2'd3;

    // Controller timing registers followed by PHY delay config reset values.
    localparam init_entry_t RpcDefaultInit [8] = '{
        '{offset: 48'h00, data: 32'h0000_0C35, wait_cycles: 16'd0},
        '{offset: 48'h04, data: 32'h0000_0008, wait_cycles: 16'd0},
        '{offset: 48'h08, data: 32'h0004_0406, wait_cycles: 16'd0},
        '{offset: 48'h0C, data: 32'h0000_0A0A, wait_cycles: 16'd0},
        '{offset: 48'h10, data: 32'h0000_0010, wait_cycles: 16'd0},
        '{offset: 48'h14, data: 32'h0010_0010, wait_cycles: 16'd16},
        '{offset: 48'h18, data: 32'h0000_0003, wait_cycles: 16'd0},
        '{offset: 48'h1C, data: 32'h0000_0001, wait_cycles: 16'd0}
    };

    function automatic logic [AddrWidth-1:0] entry_addr(input logic [AddrWidth-1:0] base,
                                                       input logic [AddrWidth-1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/rpc_reg_init_seq.sv
// Boot-time register init sequencer: writes InitTable into the RPC controller
// reg port, stalling the external master until the sequence finishes.
module rpc_reg_init_seq
    import rpc_init_pkg::*;
#(
    parameter int unsigned NumEntries = 8,
    parameter logic [47:0] BaseAddr   = 48'h0,
    parameter int unsigned WaitWidth  = 16,
    parameter bit          AutoStart  = 1'b1,
    parameter init_entry_t InitTable [(NumEntries > 0) ? NumEntries : 1] = '{default: '0},
    parameter type         reg_req_t  = rpc_init_pkg::reg_req_t,
    parameter type         reg_rsp_t  = rpc_init_pkg::reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     start_i,
    input  reg_req_t ext_req_i,
    output reg_rsp_t ext_rsp_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output logic     busy_o,
    output logic     done_o,
    output logic     error_o
);

    localparam int unsigned TableDepth = (NumEntries > 0) ? NumEntries : 1;
    localparam int unsigned IdxWidth   = (NumEntries > 0) ? $clog2(NumEntries + 1) : 1;
    localparam int unsigned LastIdx    = (NumEntries > 0) ? NumEntries - 1 : 0;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [WaitWidth-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  auto_pend_q, auto_pend_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    init_entry_t           cur_entry;
    logic [WaitWidth-1:0]  entry_wait;
    logic                  last_entry;
    logic                  seq_active;

    // Decoded table lookup keeps the index in range for any NumEntries.
    always_comb begin
        cur_entry = '0;
        for (int unsigned i = 0; i < TableDepth; i++) begin
            if (idx_q == IdxWidth'(i)) begin
                cur_entry = InitTable[i];
            end
        end
    end

    assign entry_wait = WaitWidth'(cur_entry.wait_cycles);
    assign last_entry = (idx_q == IdxWidth'(LastIdx));
    assign seq_active = (state_q == StWrite) || (state_q == StWait);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        auto_pend_d = auto_pend_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            StIdle, StDone: begin
                if ((auto_pend_q || start_i) && !ext_req_i.valid) begin
                    idx_d       = '0;
                    auto_pend_d = 1'b0;
                    error_d     = 1'b0;
                    if (NumEntries == 0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        done_d  = 1'b0;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (entry_wait != '0) begin
                        wait_cnt_d = entry_wait;
                        state_d    = StWait;
                    end else if (last_entry) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitWidth'(1)) begin
                    if (last_entry) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxWidth'(1);
                        state_d = StWrite;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WaitWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            auto_pend_q <= AutoStart;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            auto_pend_q <= auto_pend_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // External master sees a plain wire when the sequencer is not running.
    always_comb begin
        reg_req_o = ext_req_i;
        ext_rsp_o = reg_rsp_i;
        if (seq_active) begin
            ext_rsp_o = '0;
            reg_req_o = '0;
            if (state_q == StWrite) begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = '1;
                reg_req_o.addr  = entry_addr(BaseAddr, cur_entry.offset);
                reg_req_o.wdata = cur_entry.data;
            end
        end
    end

    assign busy_o  = seq_active;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_rpc_reg_init_seq.sv
// Directed bench for rpc_reg_init_seq: scoreboard of expected table writes
// plus cycle-accurate checks of stalls, waits, aborts, restarts and passthrough.
module tb_rpc_reg_init_seq;
    import rpc_init_pkg::*;

    localparam logic [47:0] BASE     = 48'hFFFF_FFFF_FFF8;
    localparam logic [47:0] ERR_ADDR = 48'hFFFF_FFFF_FFFC;
    localparam logic [31:0] CTL_RDATA = 32'hCAFE_0010;
    localparam init_entry_t TABLE [3] = '{
        '{offset: 48'h0, data: 32'h0000_000A, wait_cycles: 16'd0},
        '{offset: 48'h4, data: 32'h0000_000B, wait_cycles: 16'd5},
        '{offset: 48'h8, data: 32'h0000_000C, wait_cycles: 16'd0}
    };

    typedef struct {
        logic [47:0] addr;
        logic [31:0] data;
    } exp_wr_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     start_i = 1'b0;
    reg_req_t ext_req;
    reg_rsp_t ext_rsp;
    reg_req_t reg_req;
    reg_rsp_t reg_rsp;
    logic     busy, done, err;
    logic     ctl_ready = 1'b1;
    logic     err_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    exp_wr_t exp_q[$];
    int xfer_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rpc_reg_init_seq #(
        .NumEntries(3),
        .BaseAddr  (BASE),
        .WaitWidth (16),
        .AutoStart (1'b1),
        .InitTable (TABLE)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start_i),
        .ext_req_i(ext_req),
        .ext_rsp_o(ext_rsp),
        .reg_req_o(reg_req),
        .reg_rsp_i(reg_rsp),
        .busy_o   (busy),
        .done_o   (done),
        .error_o  (err)
    );

    // Controller model: configurable ready, error on one address, fixed rdata.
    always_comb begin
        reg_rsp.ready = ctl_ready;
        reg_rsp.rdata = CTL_RDATA;
        reg_rsp.error = err_en && reg_req.valid && (reg_req.addr == ERR_ADDR);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input int n);
        exp_wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = BASE + TABLE[i].offset;
            e.data = TABLE[i].data;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every sequencer transfer must match the next expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busy === 1'b1 && reg_req.valid === 1'b1 && reg_rsp.ready === 1'b1) begin
            xfer_cyc.push_back(cyc);
            check("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_wr_t e;
                e = exp_q.pop_front();
                check("sb_addr", 64'(reg_req.addr), 64'(e.addr));
                check("sb_wdata", 64'(reg_req.wdata), 64'(e.data));
                check("sb_wstrb", 64'(reg_req.wstrb), 64'hF);
                check("sb_write", 64'(reg_req.write), 64'd1);
            end
        end
    end

    task automatic run_seq(input int budget, output int k_done, output int n_busy,
                           output int n_idle, output int n_stall);
        k_done = -1; n_busy = 0; n_idle = 0; n_stall = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #2;
            if (done === 1'b1) begin
                k_done = k;
                break;
            end
            if (busy === 1'b1) begin
                n_busy++;
                if (reg_req.valid !== 1'b1) n_idle++;
                if (ext_rsp.ready !== 1'b0) n_stall++;
            end
        end
    endtask

    task automatic check_gaps(input string tag);
        check({tag, "_xfer_count"}, 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            check({tag, "_gap01"}, 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            check({tag, "_gap12"}, 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd6);
        end
    endtask

    task automatic check_run(input string tag, input int kd, input int nb, input int ni, input int ns,
                             input int ekd, input int enb, input int eni);
        check({tag, "_done_cycle"}, 64'(kd), 64'(ekd));
        check({tag, "_busy_cycles"}, 64'(nb), 64'(enb));
        check({tag, "_wait_cycles"}, 64'(ni), 64'(eni));
        check({tag, "_ext_stalled"}, 64'(ns), 64'd0);
    endtask

    initial begin
        int kd, nb, ni, ns;
        ext_req = '0;

        // Reset and auto-start: 3 entries with 5 waits after entry 1.
        push_seq(3);
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(err), 64'd0);
        check("rst_valid", 64'(reg_req.valid), 64'd0);
        rst_n = 1'b1;
        run_seq(40, kd, nb, ni, ns);
        check_run("auto", kd, nb, ni, ns, 9, 8, 5);
        check("auto_error", 64'(err), 64'd0);
        check_gaps("auto");

        // Rerun with entry 0 stalled for 3 cycles.
        xfer_cyc.delete();
        push_seq(3);
        ctl_ready = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        check("stall_done_cleared", 64'(done), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_valid", 64'(reg_req.valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk); #2;
            end
            check("stall_addr", 64'(reg_req.addr), 64'(BASE));
            check("stall_wdata", 64'(reg_req.wdata), 64'hA);
        end
        @(posedge clk); #2;
        check("stall_addr_last", 64'(reg_req.addr), 64'(BASE));
        ctl_ready = 1'b1;
        run_seq(40, kd, nb, ni, ns);
        check_run("stall", kd, nb, ni, ns, 8, 7, 5);
        check_gaps("stall");

        // Error on entry 1 aborts; entry 2 must never appear.
        push_seq(2);
        err_en = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        check("abort_busy", 64'(busy), 64'd1);
        run_seq(40, kd, nb, ni, ns);
        check_run("abort", kd, nb, ni, ns, 2, 1, 0);
        check("abort_error", 64'(err), 64'd1);
        err_en = 1'b0;
        ext_req = '{addr: 48'h20, write: 1'b1, wdata: 32'h55, wstrb: 4'h3, valid: 1'b1};
        #1;
        check("pass_addr", 64'(reg_req.addr), 64'h20);
        check("pass_wdata", 64'(reg_req.wdata), 64'h55);
        check("pass_wstrb", 64'(reg_req.wstrb), 64'h3);
        check("pass_ready", 64'(ext_rsp.ready), 64'd1);
        ext_req = '0;

        // External read issued while busy stalls until DONE.
        push_seq(3);
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        check("extrd_err_cleared", 64'(err), 64'd0);
        ext_req = '{addr: 48'h10, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        #1;
        check("extrd_ready_busy", 64'(ext_rsp.ready), 64'd0);
        check("extrd_seq_addr", 64'(reg_req.addr), 64'(BASE));
        run_seq(40, kd, nb, ni, ns);
        check_run("extrd", kd, nb, ni, ns, 8, 7, 5);
        check("extrd_ready_done", 64'(ext_rsp.ready), 64'd1);
        check("extrd_rdata", 64'(ext_rsp.rdata), 64'(CTL_RDATA));
        check("extrd_addr", 64'(reg_req.addr), 64'h10);
        check("extrd_write", 64'(reg_req.write), 64'd0);

        // start_i with ext bus busy is dropped.
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        check("blocked_busy", 64'(busy), 64'd0);
        check("blocked_done", 64'(done), 64'd1);
        @(posedge clk); #2;
        check("blocked_busy_later", 64'(busy), 64'd0);

        // Same pulse with bus idle reruns the sequence.
        ext_req = '0;
        push_seq(3);
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        check("rerun_done_cleared", 64'(done), 64'd0);
        check("rerun_busy", 64'(busy), 64'd1);
        run_seq(40, kd, nb, ni, ns);
        check_run("rerun", kd, nb, ni, ns, 8, 7, 5);

        // Reset pulse during the wait after entry 1 restarts from entry 0.
        push_seq(2);
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_in_wait_busy", 64'(busy), 64'd1);
        check("midrst_in_wait_valid", 64'(reg_req.valid), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_error", 64'(err), 64'd0);
        check("midrst_valid", 64'(reg_req.valid), 64'd0);
        push_seq(3);
        xfer_cyc.delete();
        rst_n = 1'b1;
        run_seq(40, kd, nb, ni, ns);
        check_run("midrst", kd, nb, ni, ns, 9, 8, 5);
        check_gaps("midrst");
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
